pdp_pool1d_lanes: RTL and testbench

- Parametrised horizontal (1D) pooling engine; successor to the fixed single-lane int8 cal1d stage of the PDP core.
- Takes a per-line stream of LANES channels per beat and injects left/right padding columns.
- Supports overlapping windows (stride < kernel) through a KMAX-deep column history.
- Emits per-window max, min or sum (for downstream reciprocal averaging) toward the 2D stage.

---
 rtl/pdp_pool_pkg.sv | 24 ++
 rtl/pdp_pool1d_reduce.sv | 51 +++++
 rtl/pdp_pool1d_lanes.sv | 225 ++++++++++++++++++++++
 tb/tb_pdp_pool1d_lanes.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdp_pool_pkg.sv
// Shared types for the PDP horizontal pooling stage: pool-type encodings,
// FSM states and the output-width derivation.
package pdp_pool_pkg;

    typedef enum logic [1:0] {
        POOL_SUM  = 2'd0,
        POOL_MAX  = 2'd1,
        POOL_MIN  = 2'd2,
        POOL_RSVD = 2'd3
    } pool_type_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PAD_L,
        ST_DATA,
        ST_PAD_R,
        ST_FLUSH
    } pool_state_t;

    function automatic int ow_of(input int dw, input int kmax);
        return dw + $clog2(kmax);
    endfunction

endpackage

// File: rtl/pdp_pool1d_reduce.sv
// Combinational single-lane reduction over the newest kernel_w history entries.
// Pad entries count as pad_value in sum mode and are skipped for max/min.
module pdp_pool1d_reduce
    import pdp_pool_pkg::*;
#(
    parameter  int DW   = 8,
    parameter  int KMAX = 8,
    localparam int OW   = ow_of(DW, KMAX),
    localparam int KW   = $clog2(KMAX) + 1
) (
    input  logic [KMAX*DW-1:0] col,
    input  logic [KMAX-1:0]    pad,
    input  logic [KW-1:0]      kernel_w,
    input  logic [1:0]         pool_type,
    input  logic [DW-1:0]      pad_value,
    output logic [OW-1:0]      result
);

    logic signed [OW-1:0] sum;
    logic signed [OW-1:0] best;
    logic signed [OW-1:0] elem;
    logic signed [OW-1:0] pad_ext;
    logic                 any;
    logic                 use_max;
    logic                 use_min;

    assign pad_ext = {{(OW-DW){pad_value[DW-1]}}, pad_value};
    assign use_max = (pool_type == POOL_MAX);
    assign use_min = (pool_type == POOL_MIN);

    // best starts at the pad value so an all-padding window yields it directly
    always_comb begin
        sum  = '0;
        best = pad_ext;
        elem = '0;
        any  = 1'b0;
        for (int unsigned k = 0; k < KMAX; k++) begin
            if (k < 32'(kernel_w)) begin
                elem = pad[k] ? pad_ext
                              : {{(OW-DW){col[k*DW+DW-1]}}, col[k*DW +: DW]};
                sum  = sum + elem;
                if (!pad[k] && (!any || (use_min ? (elem < best) : (elem > best)))) begin
                    best = elem;
                    any  = 1'b1;
                end
            end
        end
        result = (use_max || use_min) ? best : sum;
    end

endmodule

// File: rtl/pdp_pool1d_lanes.sv
// Multi-lane horizontal pooling engine: pads each line, tracks overlapping
// windows through a column history and emits one reduced beat per window.
module pdp_pool1d_lanes
    import pdp_pool_pkg::*;
#(
    parameter  int LANES = 1,
    parameter  int DW    = 8,
    parameter  int KMAX  = 8,
    parameter  int WW    = 13,
    localparam int OW    = ow_of(DW, KMAX),
    localparam int KW    = $clog2(KMAX) + 1
) (
    input  logic                  autosa_core_clk,
    input  logic                  autosa_core_rstn,
    input  logic                  op_start,
    input  logic [1:0]            cfg_pool_type,
    input  logic [KW-1:0]         cfg_kernel_w,
    input  logic [3:0]            cfg_stride_w,
    input  logic [2:0]            cfg_pad_left,
    input  logic [2:0]            cfg_pad_right,
    input  logic [DW-1:0]         cfg_pad_value,
    input  logic [WW-1:0]         cfg_in_width,
    input  logic [WW-1:0]         cfg_lines,
    input  logic [LANES*DW-1:0]   in_pd,
    input  logic                  in_pvld,
    output logic                  in_prdy,
    output logic [LANES*OW-1:0]   out_pd,
    output logic                  out_last,
    output logic                  out_pvld,
    input  logic                  out_prdy,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = WW + 2;
    localparam int BW = LANES * DW;

    pool_state_t state;

    logic [1:0]    pool_type;
    logic [KW-1:0] kernel_w;
    logic [3:0]    stride_w;
    logic [2:0]    pad_left;
    logic [2:0]    pad_right;
    logic [DW-1:0] pad_value;
    logic [WW-1:0] in_width;
    logic [WW-1:0] lines;
    logic [CW-1:0] pw_m1;
    logic          legal;

    // History holds the KMAX-1 previous columns; the current column completes the window
    logic [KMAX-2:0][BW-1:0] hist_d;
    logic [KMAX-2:0]         hist_p;
    logic [KMAX-1:0][BW-1:0] win_d;
    logic [KMAX-1:0]         win_p;

    logic [CW-1:0] vcol;
    logic [CW-1:0] next_end;
    logic [WW-1:0] col_cnt;
    logic [WW-1:0] line_cnt;
    logic [2:0]    pad_cnt;

    logic          can_out;
    logic          adv;
    logic          hit;
    logic [CW-1:0] start_pw_m1;
    logic          start_legal;
    logic [LANES*OW-1:0] red_pd;

    assign can_out = !out_pvld || out_prdy;
    assign in_prdy = (state == ST_DATA) && can_out;
    assign adv     = can_out && ((state == ST_PAD_L) || (state == ST_PAD_R) ||
                                 ((state == ST_DATA) && in_pvld));
    assign hit     = legal && (vcol == next_end);

    assign start_pw_m1 = CW'(cfg_pad_left) + CW'(cfg_in_width) + CW'(cfg_pad_right);
    assign start_legal = (cfg_kernel_w != '0) && (cfg_stride_w != '0) &&
                         (cfg_kernel_w <= KW'(KMAX)) &&
                         (CW'(cfg_kernel_w) <= start_pw_m1 + CW'(1));

    always_comb begin
        win_d    = '0;
        win_p    = '0;
        win_d[0] = in_pd;
        win_p[0] = (state != ST_DATA);
        for (int unsigned k = 1; k < KMAX; k++) begin
            win_d[k] = hist_d[k-1];
            win_p[k] = hist_p[k-1];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [KMAX*DW-1:0] col;
        always_comb begin
            col = '0;
            for (int unsigned k = 0; k < KMAX; k++) begin
                col[k*DW +: DW] = win_d[k][l*DW +: DW];
            end
        end
        pdp_pool1d_reduce #(
            .DW   (DW),
            .KMAX (KMAX)
        ) u_reduce (
            .col       (col),
            .pad       (win_p),
            .kernel_w  (kernel_w),
            .pool_type (pool_type),
            .pad_value (pad_value),
            .result    (red_pd[l*OW +: OW])
        );
    end

    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            state     <= ST_IDLE;
            pool_type <= '0;
            kernel_w  <= '0;
            stride_w  <= '0;
            pad_left  <= '0;
            pad_right <= '0;
            pad_value <= '0;
            in_width  <= '0;
            lines     <= '0;
            pw_m1     <= '0;
            legal     <= 1'b0;
            hist_d    <= '0;
            hist_p    <= '1;
            vcol      <= '0;
            next_end  <= '0;
            col_cnt   <= '0;
            line_cnt  <= '0;
            pad_cnt   <= '0;
            out_pd    <= '0;
            out_last  <= 1'b0;
            out_pvld  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (out_pvld && out_prdy) out_pvld <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (op_start) begin
                        pool_type <= cfg_pool_type;
                        kernel_w  <= cfg_kernel_w;
                        stride_w  <= cfg_stride_w;
                        pad_left  <= cfg_pad_left;
                        pad_right <= cfg_pad_right;
                        pad_value <= cfg_pad_value;
                        in_width  <= cfg_in_width;
                        lines     <= cfg_lines;
                        pw_m1     <= start_pw_m1;
                        legal     <= start_legal;
                        line_cnt  <= '0;
                        hist_d    <= '0;
                        hist_p    <= '1;
                        vcol      <= '0;
                        next_end  <= CW'(cfg_kernel_w) - CW'(1);
                        col_cnt   <= '0;
                        pad_cnt   <= '0;
                        busy      <= 1'b1;
                        state     <= (cfg_pad_left != '0) ? ST_PAD_L : ST_DATA;
                    end
                end

                ST_PAD_L, ST_DATA, ST_PAD_R: begin
                    if (adv) begin
                        hist_d <= win_d[KMAX-2:0];
                        hist_p <= win_p[KMAX-2:0];
                        vcol   <= vcol + CW'(1);
                        if (hit) begin
                            out_pd   <= red_pd;
                            out_pvld <= 1'b1;
                            out_last <= (next_end + CW'(stride_w)) > pw_m1;
                            next_end <= next_end + CW'(stride_w);
                        end
                        if (state == ST_PAD_L) begin
                            if ({1'b0, pad_cnt} + 4'd1 == {1'b0, pad_left}) begin
                                pad_cnt <= '0;
                                state   <= ST_DATA;
                            end else begin
                                pad_cnt <= pad_cnt + 3'd1;
                            end
                        end else if (state == ST_DATA) begin
                            if (col_cnt == in_width) begin
                                col_cnt <= '0;
                                state   <= (pad_right != '0) ? ST_PAD_R : ST_FLUSH;
                            end else begin
                                col_cnt <= col_cnt + WW'(1);
                            end
                        end else begin
                            if ({1'b0, pad_cnt} + 4'd1 == {1'b0, pad_right}) begin
                                pad_cnt <= '0;
                                state   <= ST_FLUSH;
                            end else begin
                                pad_cnt <= pad_cnt + 3'd1;
                            end
                        end
                    end
                end

                ST_FLUSH: begin
                    if (can_out) begin
                        if (line_cnt == lines) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            line_cnt <= line_cnt + WW'(1);
                            hist_d   <= '0;
                            hist_p   <= '1;
                            vcol     <= '0;
                            next_end <= CW'(kernel_w) - CW'(1);
                            state    <= (pad_left != '0) ? ST_PAD_L : ST_DATA;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pdp_pool1d_lanes.sv
// Scoreboard bench for pdp_pool1d_lanes with four lanes: directed pooling
// cases, illegal configs, randomised back-pressure and mid-line reset.
`timescale 1ns/1ps
module tb_pdp_pool1d_lanes;

    localparam int LANES = 4;
    localparam int DW    = 8;
    localparam int KMAX  = 8;
    localparam int WW    = 13;
    localparam int OW    = 11;
    localparam int KW    = 4;

    typedef logic [LANES*DW-1:0] beat_t;
    typedef logic [LANES*OW-1:0] word_t;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              op_start = 1'b0;
    logic [1:0]        cfg_pool_type = '0;
    logic [KW-1:0]     cfg_kernel_w = '0;
    logic [3:0]        cfg_stride_w = '0;
    logic [2:0]        cfg_pad_left = '0;
    logic [2:0]        cfg_pad_right = '0;
    logic [DW-1:0]     cfg_pad_value = '0;
    logic [WW-1:0]     cfg_in_width = '0;
    logic [WW-1:0]     cfg_lines = '0;
    beat_t             in_pd = '0;
    logic              in_pvld = 1'b0;
    logic              in_prdy;
    word_t             out_pd;
    logic              out_last;
    logic              out_pvld;
    logic              out_prdy = 1'b1;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    pdp_pool1d_lanes #(
        .LANES (LANES),
        .DW    (DW),
        .KMAX  (KMAX),
        .WW    (WW)
    ) dut (
        .autosa_core_clk  (clk),
        .autosa_core_rstn (rstn),
        .op_start         (op_start),
        .cfg_pool_type    (cfg_pool_type),
        .cfg_kernel_w     (cfg_kernel_w),
        .cfg_stride_w     (cfg_stride_w),
        .cfg_pad_left     (cfg_pad_left),
        .cfg_pad_right    (cfg_pad_right),
        .cfg_pad_value    (cfg_pad_value),
        .cfg_in_width     (cfg_in_width),
        .cfg_lines        (cfg_lines),
        .in_pd            (in_pd),
        .in_pvld          (in_pvld),
        .in_prdy          (in_prdy),
        .out_pd           (out_pd),
        .out_last         (out_last),
        .out_pvld         (out_pvld),
        .out_prdy         (out_prdy),
        .busy             (busy),
        .done             (done)
    );

    int    n_cmp = 0;
    int    n_err = 0;
    int    done_cnt = 0;
    word_t exp_pd[$];
    logic  exp_last[$];
    logic  prev_stall = 1'b0;
    word_t prev_pd;
    logic  prev_last;

    // Scoreboard pop on every accepted output; also checks hold-while-stalled
    always @(negedge clk) begin
        word_t e_pd;
        logic  e_last;
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (prev_stall) begin
                n_cmp++;
                if (!out_pvld || out_pd !== prev_pd || out_last !== prev_last) begin
                    n_err++;
                    $display("FAIL stall_hold: pvld=%0b pd=%h last=%0b, required pvld=1 pd=%h last=%0b",
                             out_pvld, out_pd, out_last, prev_pd, prev_last);
                end
            end
            if (out_pvld && out_prdy) begin
                n_cmp++;
                if (exp_pd.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_out: got pd=%h last=%0b, required no output", out_pd, out_last);
                end else begin
                    e_pd   = exp_pd.pop_front();
                    e_last = exp_last.pop_front();
                    if (out_pd !== e_pd || out_last !== e_last) begin
                        n_err++;
                        $display("FAIL out_beat: got pd=%h last=%0b, required pd=%h last=%0b",
                                 out_pd, out_last, e_pd, e_last);
                    end
                end
            end
            prev_stall = out_pvld && !out_prdy;
            prev_pd    = out_pd;
            prev_last  = out_last;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_rep(input int v, input logic last);
        word_t w;
        for (int l = 0; l < LANES; l++) w[l*OW +: OW] = OW'(v);
        exp_pd.push_back(w);
        exp_last.push_back(last);
    endtask

    // Golden model: windows by direct indexing into the padded line
    task automatic model_line(input int pt, input int k, input int s, input int pl, input int pr,
                              input int pv, input beat_t cols[$]);
        int    n;
        int    p;
        int    acc;
        int    best;
        int    v;
        int    res;
        bit    any;
        bit    ispad;
        beat_t cw;
        word_t w;
        n = cols.size();
        p = pl + n + pr;
        if (k < 1 || s < 1 || k > p || k > KMAX) return;
        for (int e = k - 1; e < p; e += s) begin
            for (int l = 0; l < LANES; l++) begin
                acc = 0; best = 0; any = 0;
                for (int c = e - k + 1; c <= e; c++) begin
                    ispad = (c < pl) || (c >= pl + n);
                    if (ispad) begin
                        v = pv;
                    end else begin
                        cw = cols[c - pl];
                        v  = int'($signed(cw[l*DW +: DW]));
                    end
                    acc += v;
                    if (!ispad && (!any || (pt == 2 ? v < best : v > best))) begin
                        best = v;
                        any  = 1;
                    end
                end
                res = (pt == 1 || pt == 2) ? (any ? best : pv) : acc;
                w[l*OW +: OW] = OW'(res);
            end
            exp_pd.push_back(w);
            exp_last.push_back(e + s > p - 1);
        end
    endtask

    task automatic start_op(input int pt, input int k, input int s, input int pl, input int pr,
                            input int pv, input int w, input int lines);
        @(posedge clk); #1;
        cfg_pool_type = 2'(pt);
        cfg_kernel_w  = KW'(k);
        cfg_stride_w  = 4'(s);
        cfg_pad_left  = 3'(pl);
        cfg_pad_right = 3'(pr);
        cfg_pad_value = DW'(pv);
        cfg_in_width  = WW'(w - 1);
        cfg_lines     = WW'(lines - 1);
        op_start      = 1'b1;
        @(posedge clk); #1;
        op_start      = 1'b0;
    endtask

    task automatic feed_beat(input beat_t d, output bit ok);
        in_pd   = d;
        in_pvld = 1'b1;
        ok      = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (in_prdy) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        in_pvld = 1'b0;
    endtask

    task automatic feed_vals(input int vals[8], input int n, output bit ok);
        bit one;
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            feed_beat({LANES{DW'(vals[i])}}, one);
            if (!one) ok = 1'b0;
        end
    endtask

    task automatic wait_done(input int d0, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (done_cnt > d0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({in_prdy, out_pvld, out_last, busy, done} !== 5'b0 || out_pd !== '0) begin
            n_err++;
            $display("FAIL reset_state: prdy/pvld/last/busy/done=%b pd=%h, required 00000 pd=0",
                     {in_prdy, out_pvld, out_last, busy, done}, out_pd);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0 || in_prdy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: busy=%0b prdy=%0b, required 0 0", busy, in_prdy);
        end
    endtask

    task automatic test_max_basic();
        int d0 = done_cnt;
        bit ok_in, ok_done;
        push_rep(5, 0); push_rep(5, 0); push_rep(4, 1);
        start_op(1, 3, 1, 0, 0, 0, 5, 1);
        feed_vals('{1, 5, 2, -3, 4, 0, 0, 0}, 5, ok_in);
        wait_done(d0, ok_done);
        n_cmp++;
        if (!ok_in || !ok_done) begin
            n_err++;
            $display("FAIL max_basic_timeout: in_ok=%0b done_ok=%0b, required 1 1", ok_in, ok_done);
        end
        n_cmp++;
        if (exp_pd.size() != 0 || done_cnt != d0 + 1) begin
            n_err++;
            $display("FAIL max_basic_end: pending=%0d dones=%0d, required 0 1", exp_pd.size(), done_cnt - d0);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL max_basic_busy: busy=%0b, required 0", busy);
        end
    endtask

    task automatic test_sum_pad();
        int d0 = done_cnt;
        bit ok_in, ok_done;
        push_rep(2, 0); push_rep(9, 0); push_rep(5, 1);
        start_op(0, 2, 2, 1, 1, -1, 4, 1);
        feed_vals('{3, 4, 5, 6, 0, 0, 0, 0}, 4, ok_in);
        wait_done(d0, ok_done);
        n_cmp++;
        if (!ok_in || !ok_done || exp_pd.size() != 0 || done_cnt != d0 + 1) begin
            n_err++;
            $display("FAIL sum_pad_end: in_ok=%0b done_ok=%0b pending=%0d dones=%0d, required 1 1 0 1",
                     ok_in, ok_done, exp_pd.size(), done_cnt - d0);
        end
    endtask

    task automatic test_min_pad();
        int d0 = done_cnt;
        bit ok_in, ok_done;
        push_rep(7, 0); push_rep(2, 0); push_rep(2, 1);
        start_op(2, 3, 1, 2, 0, -100, 3, 1);
        feed_vals('{7, 2, 9, 0, 0, 0, 0, 0}, 3, ok_in);
        wait_done(d0, ok_done);
        n_cmp++;
        if (!ok_in || !ok_done || exp_pd.size() != 0) begin
            n_err++;
            $display("FAIL min_pad_end: in_ok=%0b done_ok=%0b pending=%0d, required 1 1 0",
                     ok_in, ok_done, exp_pd.size());
        end
        // Single-column windows over pure padding fall back to the pad value
        d0 = done_cnt;
        push_rep(5, 0); push_rep(-3, 0); push_rep(5, 1);
        start_op(1, 1, 1, 1, 1, 5, 1, 1);
        feed_vals('{-3, 0, 0, 0, 0, 0, 0, 0}, 1, ok_in);
        wait_done(d0, ok_done);
        n_cmp++;
        if (!ok_in || !ok_done || exp_pd.size() != 0) begin
            n_err++;
            $display("FAIL pad_only_end: in_ok=%0b done_ok=%0b pending=%0d, required 1 1 0",
                     ok_in, ok_done, exp_pd.size());
        end
    endtask

    task automatic test_stride_skip();
        int d0 = done_cnt;
        bit ok_in, ok_done;
        push_rep(10, 0); push_rep(13, 0); push_rep(16, 1);
        start_op(0, 1, 3, 0, 2, 0, 7, 1);
        // A second start while busy must be ignored
        cfg_kernel_w = KW'(2);
        cfg_pad_right = 3'd0;
        op_start = 1'b1;
        @(posedge clk); #1;
        op_start = 1'b0;
        feed_vals('{10, 11, 12, 13, 14, 15, 16, 0}, 7, ok_in);
        wait_done(d0, ok_done);
        n_cmp++;
        if (!ok_in || !ok_done || exp_pd.size() != 0 || done_cnt != d0 + 1) begin
            n_err++;
            $display("FAIL stride_skip_end: in_ok=%0b done_ok=%0b pending=%0d dones=%0d, required 1 1 0 1",
                     ok_in, ok_done, exp_pd.size(), done_cnt - d0);
        end
    endtask

    task automatic test_illegal();
        int d0 = done_cnt;
        bit ok_in, ok_done;
        start_op(1, 0, 1, 0, 0, 0, 3, 2);
        feed_vals('{1, 2, 3, 4, 5, 6, 0, 0}, 6, ok_in);
        wait_done(d0, ok_done);
        n_cmp++;
        if (!ok_in || !ok_done || done_cnt != d0 + 1) begin
            n_err++;
            $display("FAIL illegal_k0: in_ok=%0b done_ok=%0b dones=%0d, required 1 1 1",
                     ok_in, ok_done, done_cnt - d0);
        end
        d0 = done_cnt;
        start_op(0, 5, 1, 0, 0, 0, 3, 1);
        feed_vals('{1, 2, 3, 0, 0, 0, 0, 0}, 3, ok_in);
        wait_done(d0, ok_done);
        n_cmp++;
        if (!ok_in || !ok_done || done_cnt != d0 + 1) begin
            n_err++;
            $display("FAIL illegal_wide_k: in_ok=%0b done_ok=%0b dones=%0d, required 1 1 1",
                     ok_in, ok_done, done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back();
        int    pts[2] = '{1, 0};
        int    d0;
        bit    ok_in;
        bit    ok_done;
        beat_t line_q[$];
        beat_t all_q[$];
        for (int t = 0; t < 2; t++) begin
            d0 = done_cnt;
            all_q.delete();
            for (int ln = 0; ln < 3; ln++) begin
                line_q.delete();
                for (int c = 0; c < 10; c++) line_q.push_back(beat_t'($urandom));
                model_line(pts[t], 3, 2, 1, 2, -2, line_q);
                foreach (line_q[i]) all_q.push_back(line_q[i]);
            end
            start_op(pts[t], 3, 2, 1, 2, -2, 10, 3);
            ok_in = 1'b1;
            fork
                begin
                    bit one;
                    foreach (all_q[i]) begin
                        feed_beat(all_q[i], one);
                        if (!one) ok_in = 1'b0;
                    end
                end
                begin
                    for (int c = 0; c < 4000 && done_cnt == d0; c++) begin
                        @(posedge clk); #1;
                        out_prdy = 1'($urandom_range(0, 1));
                    end
                    out_prdy = 1'b1;
                end
            join
            wait_done(d0, ok_done);
            repeat (10) @(negedge clk);
            n_cmp++;
            if (!ok_in || !ok_done || exp_pd.size() != 0) begin
                n_err++;
                $display("FAIL b2b_drain type=%0d: in_ok=%0b done_ok=%0b pending=%0d, required 1 1 0",
                         pts[t], ok_in, ok_done, exp_pd.size());
            end
            n_cmp++;
            if (done_cnt != d0 + 1) begin
                n_err++;
                $display("FAIL b2b_done_count type=%0d: dones=%0d, required 1", pts[t], done_cnt - d0);
            end
        end
    endtask

    task automatic test_reset_mid();
        start_op(1, 1, 1, 0, 0, 0, 3, 1);
        out_prdy = 1'b0;
        in_pd    = {LANES{8'd9}};
        in_pvld  = 1'b1;
        @(posedge clk); #1;
        in_pvld  = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (out_pvld !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_pre: pvld=%0b busy=%0b, required 1 1", out_pvld, busy);
        end
        #2;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if ({in_prdy, out_pvld, out_last, busy, done} !== 5'b0 || out_pd !== '0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: prdy/pvld/last/busy/done=%b pd=%h, required 00000 pd=0",
                     {in_prdy, out_pvld, out_last, busy, done}, out_pd);
        end
        exp_pd.delete();
        exp_last.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn     = 1'b1;
        out_prdy = 1'b1;
        test_max_basic();
    endtask

    initial begin
        test_reset();
        test_max_basic();
        test_sum_pad();
        test_min_pad();
        test_stride_skip();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
